// File: rtl/qam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qam_pkg                                                                    |
// | Shared constants, carrier LUTs and symbol decode for the 4-QAM modulator.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package qam_pkg;

  localparam int WORD_W          = 8;
  localparam int SAMPLES_PER_SYM = 8;
  localparam int LUT_W           = 8;

  typedef logic signed [LUT_W-1:0] lut_t;

  // One full carrier period, amplitude 63 so that |cos + sin| stays within 8 bits.
  localparam lut_t COS_LUT [SAMPLES_PER_SYM] = '{
    8'sd63, 8'sd45, 8'sd0, -8'sd45, -8'sd63, -8'sd45, 8'sd0, 8'sd45
  };
  localparam lut_t SIN_LUT [SAMPLES_PER_SYM] = '{
    8'sd0, 8'sd45, 8'sd63, 8'sd45, 8'sd0, -8'sd45, -8'sd63, -8'sd45
  };

  typedef struct packed {
    logic i_neg;
    logic q_neg;
  } iq_sign_t;

  function automatic iq_sign_t decode_symbol(input logic [1:0] symbol);
    iq_sign_t s;
    s.i_neg = symbol[1];
    s.q_neg = symbol[0];
    return s;
  endfunction

endpackage : qam_pkg
`default_nettype wire

// File: rtl/qam_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qam_serializer                                                             |
// | Holds the current sample word and shifts it out LSB first with an MSB      |
// | strobe; reloads in parallel on the last bit of each word.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module qam_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] load_word,
  output logic              data_bit_out,
  output logic              data_out_complete_bit
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_bit;

  always_comb begin
    last_bit  = (bit_cnt_q == C_LAST_BIT);
    // Power-of-two width lets the counter wrap naturally.
    bit_cnt_d = bit_cnt_q + 1'b1;
    word_d    = last_bit ? load_word : word_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      word_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
    end
  end

  assign data_bit_out          = word_q[bit_cnt_q];
  assign data_out_complete_bit = last_bit;

endmodule : qam_serializer
`default_nettype wire

// File: rtl/qam_mod_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qam_mod_top                                                                |
// | 4-QAM modulator: 8 carrier samples per symbol (I*cos + Q*sin), serialised. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module qam_mod_top
  import qam_pkg::*;
#(
  parameter int WORD_W          = qam_pkg::WORD_W,
  parameter int SAMPLES_PER_SYM = qam_pkg::SAMPLES_PER_SYM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] data_in,
  output logic       data_bit_out,
  output logic       data_out_complete_bit
);

  localparam int IDX_W = $clog2(SAMPLES_PER_SYM);
  localparam int ACC_W = LUT_W + 1;

  logic [IDX_W-1:0]        samp_idx_q, samp_idx_d, next_idx;
  logic [1:0]              sym_q, sym_d, cur_sym;
  iq_sign_t                sign;
  logic signed [ACC_W-1:0] cos_ext, sin_ext, i_term, q_term, sum;
  logic [WORD_W-1:0]       load_word;
  logic                    boundary;

  always_comb begin
    next_idx = samp_idx_q + 1'b1;
    // The new symbol is used directly on the first sample so it costs no extra word.
    cur_sym  = (next_idx == '0) ? data_in : sym_q;
    sign     = decode_symbol(cur_sym);
    cos_ext  = ACC_W'(COS_LUT[next_idx]);
    sin_ext  = ACC_W'(SIN_LUT[next_idx]);
    i_term   = sign.i_neg ? -cos_ext : cos_ext;
    q_term   = sign.q_neg ? -sin_ext : sin_ext;
    sum      = i_term + q_term;
    load_word = WORD_W'(sum);

    samp_idx_d = samp_idx_q;
    sym_d      = sym_q;
    if (boundary) begin
      samp_idx_d = next_idx;
      if (next_idx == '0) begin
        sym_d = data_in;
      end
    end
  end

  // Index starts at the last sample so the first boundary after reset loads j = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_idx_q <= '1;
      sym_q      <= '0;
    end else begin
      samp_idx_q <= samp_idx_d;
      sym_q      <= sym_d;
    end
  end

  qam_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk                   (clk),
    .rst                   (rst),
    .load_word             (load_word),
    .data_bit_out          (data_bit_out),
    .data_out_complete_bit (boundary)
  );

  assign data_out_complete_bit = boundary;

endmodule : qam_mod_top
`default_nettype wire

// File: tb/tb_qam_mod_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qam_mod_top                                                             |
// | Directed self-checking bench for the 4-QAM modulator.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_qam_mod_top;

  logic       clk;
  logic       rst;
  logic [1:0] data_in;
  logic       data_bit_out;
  logic       data_out_complete_bit;

  int n_checks = 0;
  int n_fail   = 0;

  qam_mod_top dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_in               (data_in),
    .data_bit_out          (data_bit_out),
    .data_out_complete_bit (data_out_complete_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge where bit 0 of a word is on the line; returns at the next word's bit 0.
  task automatic get_word(input string tag, output logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      w[k] = data_bit_out;
      check($sformatf("%s_strobe%0d", tag, k), int'(data_out_complete_bit), (k == 7) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  task automatic read_symbol(input string tag, input int exp [8], input logic [1:0] next_din);
    logic [7:0] w;
    for (int s = 0; s < 8; s++) begin
      if (s == 4) data_in = next_din;
      get_word($sformatf("%s_s%0d", tag, s), w);
      check($sformatf("%s_word%0d", tag, s), int'($signed(w)), exp[s]);
    end
  endtask

  int exp_sym0 [8] = '{63, 90, 63, 0, -63, -90, -63, 0};
  int exp_sym1 [8] = '{63, 0, -63, -90, -63, 0, 63, 90};
  int exp_sym2 [8] = '{-63, 0, 63, 90, 63, 0, -63, -90};
  int exp_sym3 [8] = '{-63, -90, -63, 0, 63, 90, 63, 0};

  initial begin
    logic [7:0] w;
    logic [7:0] bits90;
    int last_strobe;
    int pulses;
    int period_err;

    clk     = 1'b0;
    rst     = 1'b1;
    data_in = 2'd0;
    bits90  = 8'h5A;

    #1;
    check("rst_bit_t0", int'(data_bit_out), 0);
    check("rst_strobe_t0", int'(data_out_complete_bit), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_bit_c%0d", c), int'(data_bit_out), 0);
      check($sformatf("rst_strobe_c%0d", c), int'(data_out_complete_bit), 0);
    end

    rst = 1'b0;
    get_word("zero0", w);
    check("zero0_word", int'($signed(w)), 0);

    // Symbol 0, with the serial bits of 90 checked individually.
    for (int s = 0; s < 8; s++) begin
      if (s == 4) data_in = 2'd3;
      get_word($sformatf("sym0_s%0d", s), w);
      check($sformatf("sym0_word%0d", s), int'($signed(w)), exp_sym0[s]);
      if (s == 1) begin
        for (int k = 0; k < 8; k++)
          check($sformatf("bits90_b%0d", k), int'(w[k]), int'(bits90[k]));
      end
    end

    read_symbol("sym3", exp_sym3, 2'd1);
    read_symbol("sym1", exp_sym1, 2'd2);
    read_symbol("sym2", exp_sym2, 2'd0);

    // Asynchronous reset in the middle of the word 90 of symbol 0.
    get_word("pre_j0", w);
    check("pre_j0_word", int'($signed(w)), 63);
    repeat (3) @(negedge clk);
    check("pre_rst_bit", int'(data_bit_out), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bit", int'(data_bit_out), 0);
    check("async_rst_strobe", int'(data_out_complete_bit), 0);
    repeat (2) begin
      @(negedge clk);
      check("hold_rst_bit", int'(data_bit_out), 0);
      check("hold_rst_strobe", int'(data_out_complete_bit), 0);
    end
    data_in = 2'd2;
    rst     = 1'b0;
    get_word("zero1", w);
    check("zero1_word", int'($signed(w)), 0);
    get_word("restart_j0", w);
    check("restart_j0_word", int'($signed(w)), -63);
    get_word("restart_j1", w);
    check("restart_j1_word", int'($signed(w)), 0);

    // Strobe periodicity over 1000 cycles, starting at bit 0 of a word.
    last_strobe = -1;
    pulses      = 0;
    period_err  = 0;
    for (int i = 0; i < 1000; i++) begin
      if (data_out_complete_bit === 1'b1) begin
        if (last_strobe >= 0 && (i - last_strobe) != 8) period_err++;
        if (last_strobe < 0 && i != 7) period_err++;
        last_strobe = i;
        pulses++;
      end
      @(negedge clk);
    end
    check("strobe_period_errors", period_err, 0);
    check("strobe_pulse_count", pulses, 125);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_qam_mod_top
`default_nettype wire

// File: doc/qam_mod_top.md
Name: qam_mod_top

Overview:
- 4-QAM (QPSK) modulator top level. It takes a 2-bit symbol and synthesises 8 carrier samples per symbol as 8-bit signed words (I·cos + Q·sin).
- Each word is serialised LSB-first, one bit per clock, with a strobe marking the last bit of each word.
- It sits between the symbol source and a serial sample sink or DAC interface.

Parameters:
- WORD_W, default 8: serial word width in bits. Only the default is supported and verified.
- SAMPLES_PER_SYM, default 8: carrier samples per symbol, equal to one carrier period. Only the default is supported and verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  2  symbol. Bit1 selects I (0 → +1, 1 → −1); bit0 selects Q (0 → +1, 1 → −1).
- data_bit_out  output  1  serial sample bit, LSB first.
- data_out_complete_bit  output  1  high during the clock cycle in which bit WORD_W−1 (MSB) of the current word is on data_bit_out.

Behaviour:
- State registers:
  - bit_cnt, 3 bits
  - samp_idx, 3 bits
  - sym, 2 bits
  - word, signed 8 bits
- Reset (asynchronous, active-high):
  - bit_cnt = 0, samp_idx = 7, sym = 0, word = 0.
  - Both outputs are therefore 0 while rst is high.
- Outputs are decoded from registered state only, with no combinational path from data_in:
  - data_bit_out = word[bit_cnt].
  - data_out_complete_bit = (bit_cnt == 7).
- Each rising clock edge with rst low:
  - bit_cnt increments and wraps from 7 to 0.
  - If bit_cnt == 7 (word boundary):
    - j = (samp_idx + 1) mod 8; samp_idx <= j.
    - If j == 0: sym <= data_in, and the new word uses data_in directly.
    - Otherwise: the new word uses the held sym.
    - word <= I·COS[j] + Q·SIN[j].
- Carrier look-up tables, index 0..7:
  - COS = 63, 45, 0, −45, −63, −45, 0, 45.
  - SIN = 0, 45, 63, 45, 0, −45, −63, −45.
  - |sum| ≤ 90, so the result fits 8-bit signed with no saturation.
  - Compute at ≥ 9 bits, then truncate to 8 bits (lossless).
- Timing:
  - The first 8 cycles after reset release output the reset word 0x00, with the complete strobe on the 8th cycle.
  - Sample j = 0 of the first symbol then starts.
  - One symbol spans 64 clocks.
  - data_in is sampled only on the edge that loads j = 0, so changes at any other time have no effect until the next symbol boundary.
- Reset asserted mid-word or mid-symbol aborts immediately. Restart follows the sequence above: a zero word first, then j = 0.
- Continuous operation: no gaps between words; a strobe every 8 clocks.

Decomposition:
- Package qam_pkg holds:
  - WORD_W and SAMPLES_PER_SYM constants
  - the COS/SIN LUT constant arrays
  - a symbol-to-I/Q sign decode function.
- One sub-module, qam_serializer: holds word and bit_cnt, takes the parallel load at the boundary, and drives data_bit_out and data_out_complete_bit.
- qam_mod_top holds sym, samp_idx and the sample arithmetic.

Test Plan:
- Reset: hold rst = 1 with the clock running → data_bit_out = 0 and data_out_complete_bit = 0 throughout. Assert rst asynchronously mid-word → both outputs are 0 before the next clock edge.
- After release: the first 8 bits are all 0, and the strobe is high only on cycle 8 (words are reassembled LSB-first, bit index = cycle − 1).
- data_in = 0 held: words = 63, 90, 63, 0, −63, −90, −63, 0, repeating every 64 clocks. Check serial bits of 90 (0x5A) = 0, 1, 0, 1, 1, 0, 1, 0.
- data_in = 1 → 63, 0, −63, −90, −63, 0, 63, 90. data_in = 2 → −63, 0, 63, 90, 63, 0, −63, −90. data_in = 3 → −63, −90, −63, 0, 63, 90, 63, 0.
- Change data_in mid-symbol (e.g. 0 → 3 during sample 4) → the remaining samples of that symbol stay on symbol 0, and the next symbol starts with −63.
- Strobe periodicity: over 1000 cycles, data_out_complete_bit pulses exactly every 8 clocks, one cycle wide.
